// File: rtl/pc_next_if.sv
// Bundle between the pipeline and the PC stage: redirect/stall requests in, fetch PC and status out.
// The pipeline side uses the master modport and pc_next_unit uses the slave modport.
interface pc_next_if #(
    parameter int XLEN = 32
);
    logic            stall;
    logic            br_valid;
    logic [1:0]      br_type;
    logic            br_taken;
    logic [XLEN-1:0] br_pc;
    logic [XLEN-1:0] imm_ext;
    logic [XLEN-1:0] rs1_val;
    logic [XLEN-1:0] pc_out;
    logic [XLEN-1:0] pc_plus4;
    logic [XLEN-1:0] link_addr;
    logic            fetch_valid;
    logic            flush;
    logic            misalign;
    logic [XLEN-1:0] bad_pc;

    modport master (
        output stall, br_valid, br_type, br_taken, br_pc, imm_ext, rs1_val,
        input  pc_out, pc_plus4, link_addr, fetch_valid, flush, misalign, bad_pc
    );

    modport slave (
        input  stall, br_valid, br_type, br_taken, br_pc, imm_ext, rs1_val,
        output pc_out, pc_plus4, link_addr, fetch_valid, flush, misalign, bad_pc
    );
endinterface

// File: rtl/pc_next_unit.sv
// Registered fetch-PC stage for RV32I: selects trap / redirect / hold / PC+4 every cycle.
// Optional macro PC_MISALIGN_TRAP_EN sends misaligned taken targets to TRAP_VECTOR.
module pc_next_unit #(
    parameter int              XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = '0
`ifdef PC_MISALIGN_TRAP_EN
    ,
    parameter logic [XLEN-1:0] TRAP_VECTOR  = XLEN'(32'h0000_0100)
`endif
) (
    input  logic     clk,
    input  logic     rst_n,
    pc_next_if.slave bus
);
    localparam logic [XLEN-1:0] PC_STEP    = XLEN'(4);
    localparam logic [XLEN-1:0] JALR_MASK  = ~XLEN'(1);
`ifndef PC_MISALIGN_TRAP_EN
    localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(3);
`endif

    logic [XLEN-1:0] pc_q, pc_d;
    logic            fetch_valid_q, fetch_valid_d;
    logic            flush_q, flush_d;
    logic            take;
    logic [XLEN-1:0] target_raw;
    logic [XLEN-1:0] target;
`ifdef PC_MISALIGN_TRAP_EN
    logic            misalign_q, misalign_d;
    logic [XLEN-1:0] bad_pc_q, bad_pc_d;
    logic            mis_hit;
`endif

    always_comb begin
        take       = 1'b0;
        target_raw = bus.br_pc + bus.imm_ext;
        if (bus.br_valid) begin
            case (bus.br_type)
                2'b01:   take = bus.br_taken;
                2'b10:   take = 1'b1;
                2'b11: begin
                    take       = 1'b1;
                    target_raw = (bus.rs1_val + bus.imm_ext) & JALR_MASK;
                end
                default: take = 1'b0;
            endcase
        end
    end

`ifdef PC_MISALIGN_TRAP_EN
    assign target  = target_raw;
    assign mis_hit = take & target_raw[1];
`else
    // Without the trap the low bits are simply dropped so fetch stays word-aligned.
    assign target  = target_raw & ALIGN_MASK;
`endif

    // The PC holds until fetch_valid rises so RESET_VECTOR itself is fetched.
    always_comb begin
        pc_d          = pc_q + PC_STEP;
        fetch_valid_d = 1'b1;
        flush_d       = 1'b0;
`ifdef PC_MISALIGN_TRAP_EN
        misalign_d    = 1'b0;
        bad_pc_d      = bad_pc_q;
        if (mis_hit) begin
            pc_d       = TRAP_VECTOR;
            flush_d    = 1'b1;
            misalign_d = 1'b1;
            bad_pc_d   = target;
        end else
`endif
        if (take) begin
            pc_d    = target;
            flush_d = 1'b1;
        end else if (bus.stall || !fetch_valid_q) begin
            pc_d = pc_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q          <= RESET_VECTOR;
            fetch_valid_q <= 1'b0;
            flush_q       <= 1'b0;
`ifdef PC_MISALIGN_TRAP_EN
            misalign_q    <= 1'b0;
            bad_pc_q      <= '0;
`endif
        end else begin
            pc_q          <= pc_d;
            fetch_valid_q <= fetch_valid_d;
            flush_q       <= flush_d;
`ifdef PC_MISALIGN_TRAP_EN
            misalign_q    <= misalign_d;
            bad_pc_q      <= bad_pc_d;
`endif
        end
    end

    assign bus.pc_out      = pc_q;
    assign bus.pc_plus4    = pc_q + PC_STEP;
    assign bus.link_addr   = bus.br_pc + PC_STEP;
    assign bus.fetch_valid = fetch_valid_q;
    assign bus.flush       = flush_q;
`ifdef PC_MISALIGN_TRAP_EN
    assign bus.misalign    = misalign_q;
    assign bus.bad_pc      = bad_pc_q;
`else
    assign bus.misalign    = 1'b0;
    assign bus.bad_pc      = '0;
`endif
endmodule

// File: tb/tb_pc_next_unit.sv
// Directed-vector bench for pc_next_unit: the driver queues hand-computed outcomes,
// a negedge monitor pops and compares them. Honours PC_MISALIGN_TRAP_EN.
module tb_pc_next_unit;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   failures = 0;

    typedef struct packed {
        logic [31:0] pc;
        logic        fl;
        logic        mis;
        logic [31:0] bad;
        logic [31:0] link;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;

`ifdef PC_MISALIGN_TRAP_EN
    localparam logic [31:0] JAL_PC   = 32'h0000_0100;
    localparam logic [31:0] JAL_NX   = 32'h0000_0104;
    localparam logic [31:0] JALR_PC  = 32'h0000_0100;
    localparam logic [31:0] JALR_NX  = 32'h0000_0104;
    localparam logic        MIS      = 1'b1;
    localparam logic [31:0] BAD1     = 32'h0000_0086;
    localparam logic [31:0] BAD2     = 32'h0000_1002;
`else
    localparam logic [31:0] JAL_PC   = 32'h0000_0084;
    localparam logic [31:0] JAL_NX   = 32'h0000_0088;
    localparam logic [31:0] JALR_PC  = 32'h0000_1000;
    localparam logic [31:0] JALR_NX  = 32'h0000_1004;
    localparam logic        MIS      = 1'b0;
    localparam logic [31:0] BAD1     = 32'h0000_0000;
    localparam logic [31:0] BAD2     = 32'h0000_0000;
`endif

    pc_next_if #(.XLEN(32)) bus ();

    pc_next_unit dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (sb_q.size() > 0) begin
                mon_e = sb_q.pop_front();
                chk("pc_out",      bus.pc_out,      mon_e.pc);
                chk("pc_plus4",    bus.pc_plus4,    mon_e.pc + 32'd4);
                chk("flush",       32'(bus.flush),  32'(mon_e.fl));
                chk("misalign",    32'(bus.misalign), 32'(mon_e.mis));
                chk("bad_pc",      bus.bad_pc,      mon_e.bad);
                chk("link_addr",   bus.link_addr,   mon_e.link);
                chk("fetch_valid", 32'(bus.fetch_valid), 32'd1);
            end
        end
    end

    // Called just after a negedge: drive, let one edge pass, queue its outcome.
    task automatic step(input logic st, input logic bv, input logic [1:0] bt, input logic tk,
                        input logic [31:0] bpc, input logic [31:0] imm, input logic [31:0] rs1,
                        input logic [31:0] xpc, input logic xfl, input logic xmis,
                        input logic [31:0] xbad);
        exp_t x;
        bus.stall    = st;
        bus.br_valid = bv;
        bus.br_type  = bt;
        bus.br_taken = tk;
        bus.br_pc    = bpc;
        bus.imm_ext  = imm;
        bus.rs1_val  = rs1;
        @(posedge clk);
        #1;
        x.pc   = xpc;
        x.fl   = xfl;
        x.mis  = xmis;
        x.bad  = xbad;
        x.link = bpc + 32'd4;
        sb_q.push_back(x);
        @(negedge clk);
        #1;
    endtask

    task automatic idle(input logic [31:0] xpc, input logic [31:0] xbad);
        step(1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0, 32'h0, xpc, 1'b0, 1'b0, xbad);
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_pc"},       bus.pc_out,              32'h0);
        chk({tag, "_fv"},       32'(bus.fetch_valid),    32'd0);
        chk({tag, "_flush"},    32'(bus.flush),          32'd0);
        chk({tag, "_misalign"}, 32'(bus.misalign),       32'd0);
        chk({tag, "_bad_pc"},   bus.bad_pc,              32'h0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        bus.stall = 1'b0; bus.br_valid = 1'b0; bus.br_type = 2'b00; bus.br_taken = 1'b0;
        bus.br_pc = '0;   bus.imm_ext = '0;    bus.rs1_val = '0;
        repeat (2) @(negedge clk);
        chk_reset_state("reset");
        #1;
        rst_n = 1'b1;

        idle(32'h0, 32'h0);
        idle(32'h4, 32'h0);
        idle(32'h8, 32'h0);
        idle(32'hC, 32'h0);
        idle(32'h10, 32'h0);

        repeat (3) step(1'b1, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0, 32'h0, 32'h10, 1'b0, 1'b0, 32'h0);
        idle(32'h14, 32'h0);

        step(1'b0, 1'b1, 2'b01, 1'b1, 32'h100, 32'hFFFF_FFF8, 32'h0, 32'hF8, 1'b1, 1'b0, 32'h0);
        idle(32'hFC, 32'h0);
        step(1'b0, 1'b1, 2'b01, 1'b0, 32'h100, 32'hFFFF_FFF8, 32'h0, 32'h100, 1'b0, 1'b0, 32'h0);
        step(1'b0, 1'b1, 2'b00, 1'b1, 32'h100, 32'hFFFF_FFF8, 32'h0, 32'h104, 1'b0, 1'b0, 32'h0);

        step(1'b0, 1'b1, 2'b11, 1'b0, 32'h40, 32'h1, 32'h203, 32'h204, 1'b1, 1'b0, 32'h0);
        step(1'b1, 1'b1, 2'b11, 1'b0, 32'h204, 32'h10, 32'h300, 32'h310, 1'b1, 1'b0, 32'h0);
        step(1'b1, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0, 32'h0, 32'h310, 1'b0, 1'b0, 32'h0);
        idle(32'h314, 32'h0);

        step(1'b0, 1'b1, 2'b10, 1'b0, 32'h80, 32'h6, 32'h0, JAL_PC, 1'b1, MIS, BAD1);
        idle(JAL_NX, BAD1);
        step(1'b0, 1'b1, 2'b11, 1'b0, 32'h10, 32'h1, 32'h1001, JALR_PC, 1'b1, MIS, BAD2);
        idle(JALR_NX, BAD2);

        step(1'b0, 1'b1, 2'b10, 1'b0, 32'hFFFF_FFF0, 32'hC, 32'h0, 32'hFFFF_FFFC, 1'b1, 1'b0, BAD2);
        idle(32'h0, BAD2);
        idle(32'h4, BAD2);

        step(1'b0, 1'b1, 2'b01, 1'b1, 32'h500, 32'h20, 32'h0, 32'h520, 1'b1, 1'b0, BAD2);
        bus.br_valid = 1'b1; bus.br_type = 2'b01; bus.br_taken = 1'b1;
        bus.br_pc = 32'h600; bus.imm_ext = 32'h40;
        #2;
        rst_n = 1'b0;
        #1;
        chk_reset_state("mid_reset");
        @(negedge clk);
        chk_reset_state("held_reset");
        #1;
        bus.br_valid = 1'b0; bus.br_type = 2'b00; bus.br_taken = 1'b0;
        bus.br_pc = '0; bus.imm_ext = '0;
        rst_n = 1'b1;
        idle(32'h0, 32'h0);
        idle(32'h4, 32'h0);

        for (int i = 0; i < 10 && sb_q.size() > 0; i++) @(negedge clk);
        if (sb_q.size() > 0) begin
            failures++;
            $display("FAIL drain: %0d expectations left, required 0", sb_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
